// File: rtl/udma_l2_resp_pkg.sv
// Shared constants and types for the uDMA L2 responder and its arbiter.
package udma_l2_resp_pkg;

  import udma_pkg::*;

  // Returned in place of SRAM data when a read falls outside the SRAM window.
  localparam logic [L2_DATA_WIDTH-1:0] L2_ERR_PATTERN = 32'hBADC_AB1E;

  // Encoding of the L2 wen signal: high means read, low means write.
  localparam logic WEN_READ  = 1'b1;
  localparam logic WEN_WRITE = 1'b0;

  // Requester identity; also the round-robin pointer value.
  typedef enum logic {
    PORT_RO = 1'b0,
    PORT_WO = 1'b1
  } l2_port_e;

  // One entry of the response delay line.
  typedef struct packed {
    logic     valid;
    l2_port_e port;
    logic     err;
    logic     is_read;
  } resp_slot_t;

endpackage

// File: rtl/udma_pkg.sv
// Shared uDMA-wide constants used by the L2 responder slice.
package udma_pkg;

  localparam int L2_DATA_WIDTH = 32;

endpackage

// File: rtl/udma_l2_rr_arb.sv
// Two-requester round-robin arbiter with a combinational one-hot grant.
// Bit 0 is the ro port, bit 1 is the wo port.
module udma_l2_rr_arb
  import udma_l2_resp_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  l2_port_e ptr_q;

  // Grant a lone requester at once; on contention the pointer picks the winner; nothing during reset.
  always_comb begin
    gnt = 2'b00;
    if (rst_n) begin
      if (req[0] && (!req[1] || ptr_q == PORT_RO)) begin
        gnt = 2'b01;
      end else if (req[1]) begin
        gnt = 2'b10;
      end
    end
  end

  // After any grant the pointer favours the port that lost; it holds on idle cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= PORT_RO;
    end else if (gnt[0]) begin
      ptr_q <= PORT_WO;
    end else if (gnt[1]) begin
      ptr_q <= PORT_RO;
    end
  end

endmodule

// File: rtl/udma_l2_responder.sv
// Single-SRAM L2 responder for the uDMA ro/wo ports: arbitrates the two ports,
// range-checks byte addresses against the SRAM window and returns one response
// per grant a fixed LATENCY cycles later. LATENCY must be 1 or 2.
module udma_l2_responder
  import udma_pkg::*;
  import udma_l2_resp_pkg::*;
#(
  parameter int unsigned MEM_ADDR_WIDTH = 15,
  parameter logic [31:0] BASE_ADDR      = 32'h1C00_0000,
  parameter int unsigned LATENCY        = 1
) (
  input  logic                         sys_clk_i,
  input  logic                         sys_rst_ni,

  input  logic                         L2_ro_req_i,
  output logic                         L2_ro_gnt_o,
  input  logic                         L2_ro_wen_i,
  input  logic [31:0]                  L2_ro_addr_i,
  input  logic [L2_DATA_WIDTH/8-1:0]   L2_ro_be_i,
  input  logic [L2_DATA_WIDTH-1:0]     L2_ro_wdata_i,
  output logic                         L2_ro_rvalid_o,
  output logic [L2_DATA_WIDTH-1:0]     L2_ro_rdata_o,

  input  logic                         L2_wo_req_i,
  output logic                         L2_wo_gnt_o,
  input  logic                         L2_wo_wen_i,
  input  logic [31:0]                  L2_wo_addr_i,
  input  logic [L2_DATA_WIDTH/8-1:0]   L2_wo_be_i,
  input  logic [L2_DATA_WIDTH-1:0]     L2_wo_wdata_i,
  output logic                         L2_wo_rvalid_o,
  output logic [L2_DATA_WIDTH-1:0]     L2_wo_rdata_o,

  output logic                         mem_req_o,
  output logic                         mem_we_o,
  output logic [MEM_ADDR_WIDTH-1:0]    mem_addr_o,
  output logic [L2_DATA_WIDTH/8-1:0]   mem_be_o,
  output logic [L2_DATA_WIDTH-1:0]     mem_wdata_o,
  input  logic [L2_DATA_WIDTH-1:0]     mem_rdata_i,

  output logic [15:0]                  err_cnt_o,
  input  logic                         err_clr_i
);

  localparam int BE_WIDTH = L2_DATA_WIDTH / 8;

  // Window is [BASE_ADDR, BASE_ADDR + 4*2^MEM_ADDR_WIDTH), compared in 33 bits so the top end cannot wrap.
  localparam logic [32:0] WINDOW_LO = {1'b0, BASE_ADDR};
  localparam logic [32:0] WINDOW_HI = {1'b0, BASE_ADDR} + (33'd4 << MEM_ADDR_WIDTH);

  logic [1:0]               req;
  logic [1:0]               gnt;
  logic                     granted;
  logic                     sel_wen;
  logic [31:0]              sel_addr;
  logic [BE_WIDTH-1:0]      sel_be;
  logic [L2_DATA_WIDTH-1:0] sel_wdata;
  logic                     in_range;
  logic [15:0]              err_cnt_q;
  resp_slot_t               new_slot;
  resp_slot_t [LATENCY-1:0] pipe_q;
  resp_slot_t               head;
  logic                     head_live;
  logic [L2_DATA_WIDTH-1:0] resp_mem_data;
  logic [L2_DATA_WIDTH-1:0] resp_data;

  assign req = {L2_wo_req_i, L2_ro_req_i};

  udma_l2_rr_arb i_arb (
    .clk   (sys_clk_i),
    .rst_n (sys_rst_ni),
    .req   (req),
    .gnt   (gnt)
  );

  assign L2_ro_gnt_o = gnt[0];
  assign L2_wo_gnt_o = gnt[1];
  assign granted     = gnt[0] | gnt[1];

  // The granted port's request fields; grant is one-hot so a plain mux suffices.
  assign sel_wen   = gnt[1] ? L2_wo_wen_i   : L2_ro_wen_i;
  assign sel_addr  = gnt[1] ? L2_wo_addr_i  : L2_ro_addr_i;
  assign sel_be    = gnt[1] ? L2_wo_be_i    : L2_ro_be_i;
  assign sel_wdata = gnt[1] ? L2_wo_wdata_i : L2_ro_wdata_i;

  assign in_range = ({1'b0, sel_addr} >= WINDOW_LO) && ({1'b0, sel_addr} < WINDOW_HI);

  // Out-of-range accesses never reach the SRAM, so stray writes are dropped here.
  assign mem_req_o   = granted & in_range;
  assign mem_we_o    = mem_req_o & (sel_wen == WEN_WRITE);
  assign mem_addr_o  = sel_addr[MEM_ADDR_WIDTH+1:2] - BASE_ADDR[MEM_ADDR_WIDTH+1:2];
  assign mem_be_o    = sel_be;
  assign mem_wdata_o = sel_wdata;

  // Saturating error counter; a clear wins over a simultaneous increment.
  always_ff @(posedge sys_clk_i) begin
    if (!sys_rst_ni) begin
      err_cnt_q <= '0;
    end else if (err_clr_i) begin
      err_cnt_q <= '0;
    end else if (granted && !in_range && err_cnt_q != 16'hFFFF) begin
      err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign err_cnt_o = err_cnt_q;

  assign new_slot = '{valid:   granted,
                      port:    (gnt[1] ? PORT_WO : PORT_RO),
                      err:     !in_range,
                      is_read: (sel_wen == WEN_READ)};

  generate
    if (LATENCY == 2) begin : g_lat2
      logic [L2_DATA_WIDTH-1:0] rdata_q;

      // Two-stage response line; the SRAM word is held one extra cycle to line up with the slot.
      always_ff @(posedge sys_clk_i) begin
        if (!sys_rst_ni) begin
          pipe_q  <= '0;
          rdata_q <= '0;
        end else begin
          pipe_q  <= {pipe_q[0], new_slot};
          rdata_q <= mem_rdata_i;
        end
      end

      assign resp_mem_data = rdata_q;
    end else begin : g_lat1
      // Single-stage response line; SRAM data arrives in the same cycle as the slot.
      always_ff @(posedge sys_clk_i) begin
        if (!sys_rst_ni) begin
          pipe_q <= '0;
        end else begin
          pipe_q[0] <= new_slot;
        end
      end

      assign resp_mem_data = mem_rdata_i;
    end
  endgenerate

  // Reset also masks the head so a grant made just before reset never answers.
  assign head      = pipe_q[LATENCY-1];
  assign head_live = head.valid & sys_rst_ni;
  assign resp_data = !head.is_read ? '0 :
                     head.err      ? L2_ERR_PATTERN : resp_mem_data;

  assign L2_ro_rvalid_o = head_live && (head.port == PORT_RO);
  assign L2_wo_rvalid_o = head_live && (head.port == PORT_WO);
  assign L2_ro_rdata_o  = L2_ro_rvalid_o ? resp_data : '0;
  assign L2_wo_rdata_o  = L2_wo_rvalid_o ? resp_data : '0;

endmodule

// File: tb/tb_udma_l2_responder.sv
// Self-checking bench for udma_l2_responder. Two instances (LATENCY 1 and 2)
// see identical stimulus; a cycle-indexed schedule of expected responses and a
// word-addressed reference memory predict every output.
module tb_udma_l2_responder;

  import udma_pkg::*;

  localparam int          DW       = L2_DATA_WIDTH;
  localparam int          BEW      = DW / 8;
  localparam int          MAW      = 15;
  localparam logic [31:0] BASE     = 32'h1C00_0000;
  localparam logic [31:0] ERR_WORD = 32'hBADC_AB1E;

  typedef struct packed {
    logic           req;
    logic           wen;
    logic [31:0]    addr;
    logic [BEW-1:0] be;
    logic [DW-1:0]  wdata;
  } port_stim_t;

  localparam port_stim_t IDLE = '0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  port_stim_t ro_in;
  port_stim_t wo_in;
  logic       err_clr;

  logic [1:0]     ro_gnt, wo_gnt, ro_rvalid, wo_rvalid, mem_req, mem_we;
  logic [DW-1:0]  ro_rdata  [2];
  logic [DW-1:0]  wo_rdata  [2];
  logic [DW-1:0]  mem_wdata [2];
  logic [DW-1:0]  mem_rdata [2];
  logic [MAW-1:0] mem_addr  [2];
  logic [BEW-1:0] mem_be    [2];
  logic [15:0]    err_cnt   [2];

  udma_l2_responder #(.MEM_ADDR_WIDTH(MAW), .BASE_ADDR(BASE), .LATENCY(1)) dut_lat1 (
    .sys_clk_i(clk), .sys_rst_ni(rst_n),
    .L2_ro_req_i(ro_in.req), .L2_ro_gnt_o(ro_gnt[0]), .L2_ro_wen_i(ro_in.wen),
    .L2_ro_addr_i(ro_in.addr), .L2_ro_be_i(ro_in.be), .L2_ro_wdata_i(ro_in.wdata),
    .L2_ro_rvalid_o(ro_rvalid[0]), .L2_ro_rdata_o(ro_rdata[0]),
    .L2_wo_req_i(wo_in.req), .L2_wo_gnt_o(wo_gnt[0]), .L2_wo_wen_i(wo_in.wen),
    .L2_wo_addr_i(wo_in.addr), .L2_wo_be_i(wo_in.be), .L2_wo_wdata_i(wo_in.wdata),
    .L2_wo_rvalid_o(wo_rvalid[0]), .L2_wo_rdata_o(wo_rdata[0]),
    .mem_req_o(mem_req[0]), .mem_we_o(mem_we[0]), .mem_addr_o(mem_addr[0]),
    .mem_be_o(mem_be[0]), .mem_wdata_o(mem_wdata[0]), .mem_rdata_i(mem_rdata[0]),
    .err_cnt_o(err_cnt[0]), .err_clr_i(err_clr)
  );

  udma_l2_responder #(.MEM_ADDR_WIDTH(MAW), .BASE_ADDR(BASE), .LATENCY(2)) dut_lat2 (
    .sys_clk_i(clk), .sys_rst_ni(rst_n),
    .L2_ro_req_i(ro_in.req), .L2_ro_gnt_o(ro_gnt[1]), .L2_ro_wen_i(ro_in.wen),
    .L2_ro_addr_i(ro_in.addr), .L2_ro_be_i(ro_in.be), .L2_ro_wdata_i(ro_in.wdata),
    .L2_ro_rvalid_o(ro_rvalid[1]), .L2_ro_rdata_o(ro_rdata[1]),
    .L2_wo_req_i(wo_in.req), .L2_wo_gnt_o(wo_gnt[1]), .L2_wo_wen_i(wo_in.wen),
    .L2_wo_addr_i(wo_in.addr), .L2_wo_be_i(wo_in.be), .L2_wo_wdata_i(wo_in.wdata),
    .L2_wo_rvalid_o(wo_rvalid[1]), .L2_wo_rdata_o(wo_rdata[1]),
    .mem_req_o(mem_req[1]), .mem_we_o(mem_we[1]), .mem_addr_o(mem_addr[1]),
    .mem_be_o(mem_be[1]), .mem_wdata_o(mem_wdata[1]), .mem_rdata_i(mem_rdata[1]),
    .err_cnt_o(err_cnt[1]), .err_clr_i(err_clr)
  );

  function automatic logic [DW-1:0] mergeBytes(input logic [DW-1:0] old, input logic [DW-1:0] wd,
                                               input logic [BEW-1:0] be);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < BEW; b++) begin
      if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    end
    return r;
  endfunction

  // SRAM models: data valid one cycle after a read request, junk otherwise.
  logic [DW-1:0] sram0 [int];
  logic [DW-1:0] sram1 [int];
  always @(posedge clk) begin
    if (mem_req[0] && !mem_we[0])
      mem_rdata[0] <= sram0.exists(int'(mem_addr[0])) ? sram0[int'(mem_addr[0])] : '0;
    else
      mem_rdata[0] <= DW'($urandom);
    if (mem_req[0] && mem_we[0])
      sram0[int'(mem_addr[0])] = mergeBytes(sram0.exists(int'(mem_addr[0])) ? sram0[int'(mem_addr[0])] : '0,
                                            mem_wdata[0], mem_be[0]);
    if (mem_req[1] && !mem_we[1])
      mem_rdata[1] <= sram1.exists(int'(mem_addr[1])) ? sram1[int'(mem_addr[1])] : '0;
    else
      mem_rdata[1] <= DW'($urandom);
    if (mem_req[1] && mem_we[1])
      sram1[int'(mem_addr[1])] = mergeBytes(sram1.exists(int'(mem_addr[1])) ? sram1[int'(mem_addr[1])] : '0,
                                            mem_wdata[1], mem_be[1]);
  end

  // Reference state
  logic [DW-1:0] ref_mem [int];
  bit            ro_prio;
  int            err_exp;
  int            cyc;
  bit            sched_v [2][8];
  bit            sched_p [2][8];
  logic [DW-1:0] sched_d [2][8];
  int            checks;
  int            failures;

  task automatic checkOutput(input string tag, input logic [DW-1:0] observed, input logic [DW-1:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic rst, input port_stim_t ro, input port_stim_t wo, input logic clr);
    bit            exp_ro_gnt, exp_wo_gnt, granted, in_range, is_read, exp_mem_req, ev;
    port_stim_t    sel;
    logic [32:0]   a33;
    logic [31:0]   byte_off;
    logic [DW-1:0] resp;
    int            slot, key, s;
    string         who;
    @(negedge clk);
    rst_n   = rst;
    ro_in   = ro;
    wo_in   = wo;
    err_clr = clr;
    #1;
    exp_ro_gnt  = rst && ro.req && (!wo.req || ro_prio);
    exp_wo_gnt  = rst && wo.req && !exp_ro_gnt;
    granted     = exp_ro_gnt || exp_wo_gnt;
    sel         = exp_wo_gnt ? wo : ro;
    a33         = {1'b0, sel.addr};
    in_range    = (a33 >= {1'b0, BASE}) && (a33 < ({1'b0, BASE} + (33'd4 << MAW)));
    byte_off    = sel.addr - BASE;
    is_read     = sel.wen;
    exp_mem_req = granted && in_range;
    slot        = cyc % 8;
    for (int k = 0; k < 2; k++) begin
      who = (k == 0) ? "lat1" : "lat2";
      checkOutput({who, " ro_gnt"}, DW'(ro_gnt[k]), DW'(exp_ro_gnt));
      checkOutput({who, " wo_gnt"}, DW'(wo_gnt[k]), DW'(exp_wo_gnt));
      checkOutput({who, " mem_req"}, DW'(mem_req[k]), DW'(exp_mem_req));
      if (exp_mem_req) begin
        checkOutput({who, " mem_we"}, DW'(mem_we[k]), DW'(!is_read));
        checkOutput({who, " mem_addr"}, DW'(mem_addr[k]), DW'(byte_off >> 2));
        checkOutput({who, " mem_be"}, DW'(mem_be[k]), DW'(sel.be));
        checkOutput({who, " mem_wdata"}, mem_wdata[k], sel.wdata);
      end
      ev = rst && sched_v[k][slot] && !sched_p[k][slot];
      checkOutput({who, " ro_rvalid"}, DW'(ro_rvalid[k]), DW'(ev));
      checkOutput({who, " ro_rdata"}, ro_rdata[k], ev ? sched_d[k][slot] : '0);
      ev = rst && sched_v[k][slot] && sched_p[k][slot];
      checkOutput({who, " wo_rvalid"}, DW'(wo_rvalid[k]), DW'(ev));
      checkOutput({who, " wo_rdata"}, wo_rdata[k], ev ? sched_d[k][slot] : '0);
      checkOutput({who, " err_cnt"}, DW'(err_cnt[k]), DW'(err_exp));
      sched_v[k][slot] = 1'b0;
    end
    if (!rst) begin
      for (int k = 0; k < 2; k++)
        for (int j = 0; j < 8; j++) sched_v[k][j] = 1'b0;
      ro_prio = 1'b1;
      err_exp = 0;
    end else begin
      if (granted) begin
        key = int'(byte_off >> 2);
        if (!is_read) resp = '0;
        else if (!in_range) resp = ERR_WORD;
        else resp = ref_mem.exists(key) ? ref_mem[key] : '0;
        if (!is_read && in_range)
          ref_mem[key] = mergeBytes(ref_mem.exists(key) ? ref_mem[key] : '0, sel.wdata, sel.be);
        for (int k = 0; k < 2; k++) begin
          s = (cyc + k + 1) % 8;
          sched_v[k][s] = 1'b1;
          sched_p[k][s] = exp_wo_gnt;
          sched_d[k][s] = resp;
        end
        ro_prio = exp_wo_gnt;
      end
      if (clr) err_exp = 0;
      else if (granted && !in_range && err_exp < 65535) err_exp++;
    end
    cyc++;
  endtask

  function automatic port_stim_t rd(input logic [31:0] a);
    port_stim_t s;
    s.req = 1'b1; s.wen = 1'b1; s.addr = a; s.be = '1; s.wdata = '0;
    return s;
  endfunction

  function automatic port_stim_t wr(input logic [31:0] a, input logic [DW-1:0] d, input logic [BEW-1:0] be);
    port_stim_t s;
    s.req = 1'b1; s.wen = 1'b0; s.addr = a; s.be = be; s.wdata = d;
    return s;
  endfunction

  function automatic port_stim_t randPort();
    port_stim_t  s;
    logic [31:0] a;
    case ($urandom_range(0, 9))
      0:       a = BASE - 32'($urandom_range(1, 64)) * 32'd4;
      1:       a = 32'h1C02_0000 + 32'($urandom_range(0, 63));
      2:       a = $urandom;
      default: a = BASE + 32'($urandom_range(0, 63));
    endcase
    s.req   = ($urandom_range(0, 3) != 0);
    s.wen   = 1'($urandom_range(0, 1));
    s.addr  = a;
    s.be    = BEW'($urandom);
    s.wdata = DW'($urandom);
    return s;
  endfunction

  initial begin
    rst_n    = 1'b0;
    ro_in    = IDLE;
    wo_in    = IDLE;
    err_clr  = 1'b0;
    checks   = 0;
    failures = 0;
    cyc      = 0;
    ro_prio  = 1'b1;
    err_exp  = 0;
    repeat (2) @(posedge clk);

    // Reset held with live requests: nothing granted, nothing returned
    applyStimulus(1'b0, rd(BASE + 32'd16), wr(BASE, 32'h1111_2222, 4'hF), 1'b0);

    // Single ro read returning a preloaded word
    applyStimulus(1'b1, IDLE, wr(BASE + 32'd16, 32'hCAFE_F00D, 4'hF), 1'b0);
    applyStimulus(1'b1, rd(32'h1C00_0010), IDLE, 1'b0);
    repeat (2) applyStimulus(1'b1, IDLE, IDLE, 1'b0);

    // Contention from reset alternates ro, wo, ...
    applyStimulus(1'b0, IDLE, IDLE, 1'b0);
    for (int i = 0; i < 6; i++)
      applyStimulus(1'b1, rd(BASE + 32'(i * 4)), rd(BASE + 32'h100 + 32'(i * 4)), 1'b0);
    repeat (2) applyStimulus(1'b1, IDLE, IDLE, 1'b0);

    // Partial write then read-back
    applyStimulus(1'b1, IDLE, wr(32'h1C00_0004, 32'hDEAD_BEEF, 4'b0011), 1'b0);
    applyStimulus(1'b1, rd(32'h1C00_0004), IDLE, 1'b0);
    repeat (2) applyStimulus(1'b1, IDLE, IDLE, 1'b0);

    // Window edges and error counter clear priority
    applyStimulus(1'b1, rd(32'h1C02_0000), IDLE, 1'b0);
    applyStimulus(1'b1, IDLE, IDLE, 1'b0);
    applyStimulus(1'b1, rd(32'h1C01_FFFC), IDLE, 1'b0);
    applyStimulus(1'b1, IDLE, wr(BASE - 32'd4, 32'h5555_AAAA, 4'hF), 1'b0);
    applyStimulus(1'b1, rd(32'h1C02_0004), IDLE, 1'b1);
    repeat (2) applyStimulus(1'b1, IDLE, IDLE, 1'b0);

    // Back-to-back reads of words 0,1,2
    applyStimulus(1'b1, IDLE, wr(BASE + 32'd8, 32'h0BAD_F00D, 4'hF), 1'b0);
    applyStimulus(1'b1, rd(BASE), IDLE, 1'b0);
    applyStimulus(1'b1, rd(BASE + 32'd4), IDLE, 1'b0);
    applyStimulus(1'b1, rd(BASE + 32'd8), IDLE, 1'b0);
    repeat (3) applyStimulus(1'b1, IDLE, IDLE, 1'b0);

    // Reset right after a grant drops that response and the error count
    applyStimulus(1'b1, rd(32'h2000_0000), IDLE, 1'b0);
    applyStimulus(1'b1, rd(BASE + 32'd16), IDLE, 1'b0);
    applyStimulus(1'b0, IDLE, IDLE, 1'b0);
    repeat (2) applyStimulus(1'b1, IDLE, IDLE, 1'b0);
    applyStimulus(1'b1, rd(BASE), rd(BASE + 32'd4), 1'b0);
    repeat (2) applyStimulus(1'b1, IDLE, IDLE, 1'b0);

    // Random traffic
    for (int i = 0; i < 400; i++)
      applyStimulus($urandom_range(0, 49) != 0, randPort(), randPort(), $urandom_range(0, 19) == 0);
    repeat (3) applyStimulus(1'b1, IDLE, IDLE, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
